// File: rtl/dccm_port_arb.sv
// dccm_port_arb: shares the single-ported DCCM between the LSU (dc1 stage)
// and a DMA/loader port. The LSU has fixed priority. A starvation counter
// forces a DMA grant after a bounded wait. Load data returning from the DCCM
// is routed back to whichever requester issued the load.
// Optional performance counters are enabled by defining DCCM_ARB_PERF_EN.
module dccm_port_arb #(
   parameter int XLEN         = 32,
   parameter int STARVE_LIMIT = 8,
   parameter int DCCM_RD_LAT  = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              lsu_req_valid,
   output logic              lsu_req_ready,
   input  logic              lsu_req_wen,
   input  logic [XLEN-1:0]   lsu_req_addr,
   input  logic [XLEN-1:0]   lsu_req_wdata,
   input  logic [XLEN/8-1:0] lsu_req_wmask,
   output logic              lsu_rsp_valid,
   output logic [XLEN-1:0]   lsu_rsp_rdata,
   input  logic              dma_req_valid,
   output logic              dma_req_ready,
   input  logic              dma_req_wen,
   input  logic [XLEN-1:0]   dma_req_addr,
   input  logic [XLEN-1:0]   dma_req_wdata,
   input  logic [XLEN/8-1:0] dma_req_wmask,
   output logic              dma_rsp_valid,
   output logic [XLEN-1:0]   dma_rsp_rdata,
   output logic              dccm_en,
   output logic              dccm_wen,
   output logic [XLEN-1:0]   dccm_addr,
   output logic [XLEN-1:0]   dccm_wdata,
   output logic [XLEN/8-1:0] dccm_wmask,
   input  logic [XLEN-1:0]   dccm_rdata
`ifdef DCCM_ARB_PERF_EN
   ,
   output logic [31:0]       perf_lsu_grants,
   output logic [31:0]       perf_dma_grants,
   output logic [31:0]       perf_dma_forced,
   output logic [31:0]       perf_dma_stall_cycles
`endif
);

   localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

   logic                   lsu_gnt;
   logic                   dma_gnt;
   logic                   forced_gnt;
   logic [7:0]             cnt_q, cnt_d;
   logic                   force_q, force_d;
   logic [DCCM_RD_LAT-1:0] pv_q, pv_d;
   logic [DCCM_RD_LAT-1:0] po_q, po_d;

   // Pick at most one winner this cycle; nothing is granted while in reset
   always_comb begin
      lsu_gnt = 1'b0;
      dma_gnt = 1'b0;
      if (!rst) begin
         if (force_q && dma_req_valid) begin
            dma_gnt = 1'b1;
         end else if (lsu_req_valid) begin
            lsu_gnt = 1'b1;
         end else if (dma_req_valid) begin
            dma_gnt = 1'b1;
         end
      end
      forced_gnt    = dma_gnt && force_q;
      lsu_req_ready = lsu_gnt;
      dma_req_ready = dma_gnt;
   end

   // Steer the winning payload onto the DCCM; idle bus drives zeros
   always_comb begin
      dccm_en    = lsu_gnt | dma_gnt;
      dccm_wen   = 1'b0;
      dccm_addr  = '0;
      dccm_wdata = '0;
      dccm_wmask = '0;
      if (lsu_gnt) begin
         dccm_wen   = lsu_req_wen;
         dccm_addr  = lsu_req_addr;
         dccm_wdata = lsu_req_wdata;
         dccm_wmask = lsu_req_wmask;
      end else if (dma_gnt) begin
         dccm_wen   = dma_req_wen;
         dccm_addr  = dma_req_addr;
         dccm_wdata = dma_req_wdata;
         dccm_wmask = dma_req_wmask;
      end
   end

   // Starvation tracking: count refused DMA cycles, arm force once saturated
   always_comb begin
      cnt_d = cnt_q;
      if (!dma_req_valid || dma_gnt) begin
         cnt_d = '0;
      end else if (cnt_q != LIMIT) begin
         cnt_d = cnt_q + 8'd1;
      end
      force_d = dma_req_valid && !dma_gnt && (force_q || (cnt_q == LIMIT));
   end

   // Response pipeline: one {valid, owner} slot per cycle of read latency
   always_comb begin
      pv_d    = pv_q;
      po_d    = po_q;
      pv_d[0] = (lsu_gnt && !lsu_req_wen) || (dma_gnt && !dma_req_wen);
      po_d[0] = dma_gnt;
      for (int i = 1; i < DCCM_RD_LAT; i++) begin
         pv_d[i] = pv_q[i-1];
         po_d[i] = po_q[i-1];
      end
   end

   // Route returning read data to the requester that owns the oldest slot
   always_comb begin
      lsu_rsp_valid = 1'b0;
      lsu_rsp_rdata = '0;
      dma_rsp_valid = 1'b0;
      dma_rsp_rdata = '0;
      if (!rst && pv_q[DCCM_RD_LAT-1]) begin
         if (po_q[DCCM_RD_LAT-1]) begin
            dma_rsp_valid = 1'b1;
            dma_rsp_rdata = dccm_rdata;
         end else begin
            lsu_rsp_valid = 1'b1;
            lsu_rsp_rdata = dccm_rdata;
         end
      end
   end

   // Arbiter state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         force_q <= 1'b0;
         pv_q    <= '0;
         po_q    <= '0;
      end else begin
         cnt_q   <= cnt_d;
         force_q <= force_d;
         pv_q    <= pv_d;
         po_q    <= po_d;
      end
   end

`ifdef DCCM_ARB_PERF_EN
   logic [31:0] plsu_q, plsu_d, pdma_q, pdma_d, pfrc_q, pfrc_d, pstl_q, pstl_d;

   // Saturating event counters
   always_comb begin
      plsu_d = plsu_q;
      pdma_d = pdma_q;
      pfrc_d = pfrc_q;
      pstl_d = pstl_q;
      if (lsu_gnt && plsu_q != '1) plsu_d = plsu_q + 32'd1;
      if (dma_gnt && pdma_q != '1) pdma_d = pdma_q + 32'd1;
      if (forced_gnt && pfrc_q != '1) pfrc_d = pfrc_q + 32'd1;
      if (dma_req_valid && !dma_gnt && pstl_q != '1) pstl_d = pstl_q + 32'd1;
   end

   // Performance counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         plsu_q <= '0;
         pdma_q <= '0;
         pfrc_q <= '0;
         pstl_q <= '0;
      end else begin
         plsu_q <= plsu_d;
         pdma_q <= pdma_d;
         pfrc_q <= pfrc_d;
         pstl_q <= pstl_d;
      end
   end

   assign perf_lsu_grants       = plsu_q;
   assign perf_dma_grants       = pdma_q;
   assign perf_dma_forced       = pfrc_q;
   assign perf_dma_stall_cycles = pstl_q;
`endif

endmodule

// File: tb/tb_dccm_port_arb.sv
// tb_dccm_port_arb: directed bench for dccm_port_arb. Instance a uses
// DCCM_RD_LAT=1, instance b uses DCCM_RD_LAT=2; both see the same stimulus.
// Performance counter checks are compiled in when DCCM_ARB_PERF_EN is defined.
module tb_dccm_port_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic        lsu_req_valid, lsu_req_wen, dma_req_valid, dma_req_wen;
   logic [31:0] lsu_req_addr, lsu_req_wdata, dma_req_addr, dma_req_wdata, dccm_rdata;
   logic [3:0]  lsu_req_wmask, dma_req_wmask;

   logic        a_lsu_ready, a_lsu_rsp_valid, a_dma_ready, a_dma_rsp_valid, a_en, a_wen;
   logic [31:0] a_lsu_rsp_rdata, a_dma_rsp_rdata, a_addr, a_wdata;
   logic [3:0]  a_wmask;
   logic        b_lsu_ready, b_lsu_rsp_valid, b_dma_ready, b_dma_rsp_valid, b_en, b_wen;
   logic [31:0] b_lsu_rsp_rdata, b_dma_rsp_rdata, b_addr, b_wdata;
   logic [3:0]  b_wmask;
`ifdef DCCM_ARB_PERF_EN
   logic [31:0] a_plsu, a_pdma, a_pfrc, a_pstl, b_plsu, b_pdma, b_pfrc, b_pstl;
`endif

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   dccm_port_arb #(.XLEN(32), .STARVE_LIMIT(8), .DCCM_RD_LAT(1)) u_a (
      .clk(clk), .rst(rst),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(a_lsu_ready), .lsu_req_wen(lsu_req_wen),
      .lsu_req_addr(lsu_req_addr), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
      .lsu_rsp_valid(a_lsu_rsp_valid), .lsu_rsp_rdata(a_lsu_rsp_rdata),
      .dma_req_valid(dma_req_valid), .dma_req_ready(a_dma_ready), .dma_req_wen(dma_req_wen),
      .dma_req_addr(dma_req_addr), .dma_req_wdata(dma_req_wdata), .dma_req_wmask(dma_req_wmask),
      .dma_rsp_valid(a_dma_rsp_valid), .dma_rsp_rdata(a_dma_rsp_rdata),
      .dccm_en(a_en), .dccm_wen(a_wen), .dccm_addr(a_addr), .dccm_wdata(a_wdata),
      .dccm_wmask(a_wmask), .dccm_rdata(dccm_rdata)
`ifdef DCCM_ARB_PERF_EN
      , .perf_lsu_grants(a_plsu), .perf_dma_grants(a_pdma), .perf_dma_forced(a_pfrc),
      .perf_dma_stall_cycles(a_pstl)
`endif
   );

   dccm_port_arb #(.XLEN(32), .STARVE_LIMIT(8), .DCCM_RD_LAT(2)) u_b (
      .clk(clk), .rst(rst),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(b_lsu_ready), .lsu_req_wen(lsu_req_wen),
      .lsu_req_addr(lsu_req_addr), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
      .lsu_rsp_valid(b_lsu_rsp_valid), .lsu_rsp_rdata(b_lsu_rsp_rdata),
      .dma_req_valid(dma_req_valid), .dma_req_ready(b_dma_ready), .dma_req_wen(dma_req_wen),
      .dma_req_addr(dma_req_addr), .dma_req_wdata(dma_req_wdata), .dma_req_wmask(dma_req_wmask),
      .dma_rsp_valid(b_dma_rsp_valid), .dma_rsp_rdata(b_dma_rsp_rdata),
      .dccm_en(b_en), .dccm_wen(b_wen), .dccm_addr(b_addr), .dccm_wdata(b_wdata),
      .dccm_wmask(b_wmask), .dccm_rdata(dccm_rdata)
`ifdef DCCM_ARB_PERF_EN
      , .perf_lsu_grants(b_plsu), .perf_dma_grants(b_pdma), .perf_dma_forced(b_pfrc),
      .perf_dma_stall_cycles(b_pstl)
`endif
   );

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      lsu_req_valid = 0; lsu_req_wen = 0; lsu_req_addr = 0; lsu_req_wdata = 0; lsu_req_wmask = 0;
      dma_req_valid = 0; dma_req_wen = 0; dma_req_addr = 0; dma_req_wdata = 0; dma_req_wmask = 0;
      dccm_rdata = 0;
   endtask

   task automatic pulse_reset();
      idle_inputs();
      rst = 1;
      tick();
      tick();
      rst = 0;
   endtask

   // Outputs during reset must be quiet even with both requesters asking
   task automatic test_reset();
      idle_inputs();
      rst = 1;
      tick();
      lsu_req_valid = 1; dma_req_valid = 1; lsu_req_addr = 32'h44; dma_req_addr = 32'h88;
      #1;
      total++;
      if ({a_lsu_ready, a_dma_ready, a_en, a_wen, a_lsu_rsp_valid, a_dma_rsp_valid} !== 6'b0) begin
         $display("[TB] FAIL reset_outputs: got %b expected 000000",
                  {a_lsu_ready, a_dma_ready, a_en, a_wen, a_lsu_rsp_valid, a_dma_rsp_valid});
      end else passed++;
      total++;
      if (a_addr !== 32'h0) $display("[TB] FAIL reset_addr: got %h expected 0", a_addr);
      else passed++;
`ifdef DCCM_ARB_PERF_EN
      total++;
      if ({a_plsu, a_pdma, a_pfrc, a_pstl} !== 128'h0) $display("[TB] FAIL reset_perf: got nonzero counters");
      else passed++;
`endif
      tick();
      idle_inputs();
      rst = 0;
      tick();
      #1;
      total++;
      if ({a_en, a_addr} !== 33'h0) $display("[TB] FAIL idle_bus: en/addr %b/%h expected 0/0", a_en, a_addr);
      else passed++;
   endtask

   // Single LSU load with one-cycle read latency
   task automatic test_lsu_alone();
      pulse_reset();
      lsu_req_valid = 1; lsu_req_wen = 0; lsu_req_addr = 32'h100;
      #1;
      total++;
      if ({a_lsu_ready, a_dma_ready, a_en, a_wen} !== 4'b1010)
         $display("[TB] FAIL lsu_grant: rdy/dma/en/wen %b expected 1010", {a_lsu_ready, a_dma_ready, a_en, a_wen});
      else passed++;
      total++;
      if (a_addr !== 32'h100) $display("[TB] FAIL lsu_addr: got %h expected 00000100", a_addr);
      else passed++;
      tick();
      idle_inputs();
      dccm_rdata = 32'h12345678;
      #1;
      total++;
      if ({a_lsu_rsp_valid, a_dma_rsp_valid} !== 2'b10 || a_lsu_rsp_rdata !== 32'h12345678 || a_dma_rsp_rdata !== 32'h0)
         $display("[TB] FAIL lsu_rsp: valid %b data %h expected 10 12345678",
                  {a_lsu_rsp_valid, a_dma_rsp_valid}, a_lsu_rsp_rdata);
      else passed++;
      tick();
      #1;
      total++;
      if ({a_lsu_rsp_valid, a_dma_rsp_valid} !== 2'b00)
         $display("[TB] FAIL lsu_rsp_once: valid %b expected 00", {a_lsu_rsp_valid, a_dma_rsp_valid});
      else passed++;
   endtask

   // DMA store with LSU idle, then an LSU store with empty byte mask
   task automatic test_dma_store();
      pulse_reset();
      dma_req_valid = 1; dma_req_wen = 1; dma_req_addr = 32'h200;
      dma_req_wdata = 32'hDEADBEEF; dma_req_wmask = 4'hF;
      #1;
      total++;
      if ({a_dma_ready, a_lsu_ready, a_en, a_wen} !== 4'b1011)
         $display("[TB] FAIL dma_store_grant: rdy/lsu/en/wen %b expected 1011", {a_dma_ready, a_lsu_ready, a_en, a_wen});
      else passed++;
      total++;
      if (a_addr !== 32'h200 || a_wdata !== 32'hDEADBEEF || a_wmask !== 4'hF)
         $display("[TB] FAIL dma_store_bus: %h %h %h expected 00000200 deadbeef f", a_addr, a_wdata, a_wmask);
      else passed++;
      tick();
      idle_inputs();
      lsu_req_valid = 1; lsu_req_wen = 1; lsu_req_addr = 32'h300; lsu_req_wdata = 32'hCAFE0001; lsu_req_wmask = 4'h0;
      dccm_rdata = 32'h55555555;
      #1;
      total++;
      if ({a_dma_rsp_valid, a_lsu_rsp_valid, b_dma_rsp_valid, b_lsu_rsp_valid} !== 4'b0)
         $display("[TB] FAIL store_no_rsp: got %b expected 0000",
                  {a_dma_rsp_valid, a_lsu_rsp_valid, b_dma_rsp_valid, b_lsu_rsp_valid});
      else passed++;
      total++;
      if ({a_lsu_ready, a_en, a_wen, a_wmask} !== 7'b1110000 || a_addr !== 32'h300 || a_wdata !== 32'hCAFE0001)
         $display("[TB] FAIL zero_mask_store: rdy/en/wen/mask %b addr %h data %h expected 1110000 00000300 cafe0001",
                  {a_lsu_ready, a_en, a_wen, a_wmask}, a_addr, a_wdata);
      else passed++;
      tick();
      idle_inputs();
   endtask

   // LSU, DMA, LSU loads on consecutive cycles through the two-cycle instance
   task automatic test_back_to_back();
      logic [2:0] exp_lsu_rdy;
      logic [4:0] exp_lsu_v, exp_dma_v;
      exp_lsu_rdy = 3'b101;
      exp_lsu_v   = 5'b10100;
      exp_dma_v   = 5'b01000;
      pulse_reset();
      for (int i = 0; i < 6; i++) begin
         idle_inputs();
         dccm_rdata = 32'hA000_0000 + 32'(i);
         if (i == 0 || i == 2) begin lsu_req_valid = 1; lsu_req_addr = 32'h10 + 32'(i); end
         if (i == 1) begin dma_req_valid = 1; dma_req_addr = 32'h20; end
         #1;
         if (i < 3) begin
            total++;
            if ({b_lsu_ready, b_dma_ready, b_en} !== {exp_lsu_rdy[i], ~exp_lsu_rdy[i], 1'b1})
               $display("[TB] FAIL b2b_grant[%0d]: lsu/dma/en %b expected %b", i,
                        {b_lsu_ready, b_dma_ready, b_en}, {exp_lsu_rdy[i], ~exp_lsu_rdy[i], 1'b1});
            else passed++;
         end
         total++;
         if (b_lsu_rsp_valid !== exp_lsu_v[i] || b_dma_rsp_valid !== exp_dma_v[i] ||
             b_lsu_rsp_rdata !== (exp_lsu_v[i] ? dccm_rdata : 32'h0) ||
             b_dma_rsp_rdata !== (exp_dma_v[i] ? dccm_rdata : 32'h0))
            $display("[TB] FAIL b2b_rsp[%0d]: lsu %b/%h dma %b/%h expected %b/%b data %h", i,
                     b_lsu_rsp_valid, b_lsu_rsp_rdata, b_dma_rsp_valid, b_dma_rsp_rdata,
                     exp_lsu_v[i], exp_dma_v[i], dccm_rdata);
         else passed++;
         tick();
      end
   endtask

   // Continuous contention for 20 cycles: DMA forced on cycles 9 and 19
   task automatic test_contention();
      int bad;
      pulse_reset();
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         lsu_req_valid = 1; lsu_req_wen = 1; lsu_req_addr = 32'h400;
         dma_req_valid = 1; dma_req_wen = 1; dma_req_addr = 32'h800;
         #1;
         if (b_dma_ready !== (i == 9 || i == 19) || b_lsu_ready !== !(i == 9 || i == 19) ||
             a_dma_ready !== (i == 9 || i == 19) || a_lsu_ready !== !(i == 9 || i == 19) ||
             a_addr !== ((i == 9 || i == 19) ? 32'h800 : 32'h400)) begin
            $display("[TB] FAIL contention[%0d]: lsu_rdy %b dma_rdy %b addr %h", i, a_lsu_ready, a_dma_ready, a_addr);
            bad++;
         end
         tick();
      end
      total++;
      if (bad != 0) $display("[TB] FAIL contention_pattern: got %0d bad cycles expected 0", bad);
      else passed++;
`ifdef DCCM_ARB_PERF_EN
      total++;
      if (a_pfrc !== 32'd2 || a_plsu !== 32'd18 || a_pdma !== 32'd2 || a_pstl !== 32'd18)
         $display("[TB] FAIL perf_counts: lsu %0d dma %0d forced %0d stall %0d expected 18 2 2 18",
                  a_plsu, a_pdma, a_pfrc, a_pstl);
      else passed++;
`endif
      idle_inputs();
      tick();
   endtask

   // Reset with two loads in flight and a partly built starvation count
   task automatic test_reset_midflight();
      int wait_cycles;
      pulse_reset();
      for (int i = 0; i < 2; i++) begin
         lsu_req_valid = 1; lsu_req_wen = 0; lsu_req_addr = 32'h600 + 32'(i);
         dma_req_valid = 1; dma_req_wen = 0; dma_req_addr = 32'h700;
         tick();
      end
      rst = 1;
      #1;
      total++;
      if ({a_en, b_en, a_lsu_ready, a_dma_ready, b_lsu_rsp_valid, b_dma_rsp_valid, a_lsu_rsp_valid} !== 7'b0)
         $display("[TB] FAIL rst_midflight: got %b expected 0000000",
                  {a_en, b_en, a_lsu_ready, a_dma_ready, b_lsu_rsp_valid, b_dma_rsp_valid, a_lsu_rsp_valid});
      else passed++;
      tick();
      rst = 0;
      lsu_req_valid = 0; dma_req_valid = 0;
      #1;
      total++;
      if ({b_lsu_rsp_valid, b_dma_rsp_valid, a_lsu_rsp_valid, a_dma_rsp_valid} !== 4'b0)
         $display("[TB] FAIL rst_flush: rsp %b expected 0000",
                  {b_lsu_rsp_valid, b_dma_rsp_valid, a_lsu_rsp_valid, a_dma_rsp_valid});
      else passed++;
      lsu_req_valid = 1; dma_req_valid = 1;
      #1;
      wait_cycles = 0;
      while (b_dma_ready !== 1'b1 && wait_cycles < 20) begin
         tick();
         wait_cycles++;
      end
      total++;
      if (wait_cycles != 9) $display("[TB] FAIL rst_counter_clear: DMA granted after %0d cycles expected 9", wait_cycles);
      else passed++;
      idle_inputs();
      tick();
   endtask

   initial begin
      rst = 1;
      idle_inputs();
      test_reset();
      test_lsu_alone();
      test_dma_store();
      test_back_to_back();
      test_contention();
      test_reset_midflight();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   // Absolute time bound so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation exceeded time bound");
      $fatal(1, "[TB] timeout");
   end

endmodule
